// File: rtl/age_issue_queue_pkg.sv
// Shared constants for the age-ordered issue queue.
// Holds default sizing parameters and FU select encodings.
package issue_pkg;

    localparam int IQ_DEPTH     = 8;
    localparam int IQ_ROB_W     = 3;
    localparam int IQ_PREG_W    = 7;
    localparam int IQ_FU_W      = 3;
    localparam int IQ_NUM_WK    = 2;
    localparam int IQ_PAYLOAD_W = 112;

    typedef enum logic [2:0] {
        FU_ALU   = 3'd0,
        FU_MUL   = 3'd1,
        FU_DIV   = 3'd2,
        FU_FALU  = 3'd3,
        FU_FMUL  = 3'd4,
        FU_FDIV  = 3'd5,
        FU_LOAD  = 3'd6,
        FU_STORE = 3'd7
    } fu_e;

endpackage

// File: rtl/age_issue_queue_if.sv
// Dispatch and issue handshake bundle of the issue queue.
// master: dispatch source / issue sink; slave: the queue itself.
interface age_issue_queue_if
    import issue_pkg::*;
#(
    parameter int PAYLOAD_W = IQ_PAYLOAD_W,
    parameter int PREG_W    = IQ_PREG_W,
    parameter int FU_W      = IQ_FU_W,
    parameter int ROB_W     = IQ_ROB_W
);
    logic                 disp_valid;
    logic                 disp_ready;
    logic [PAYLOAD_W-1:0] disp_payload;
    logic [PREG_W-1:0]    disp_rs1;
    logic [PREG_W-1:0]    disp_rs2;
    logic [PREG_W-1:0]    disp_rd;
    logic                 disp_rs1_rdy;
    logic                 disp_rs2_rdy;
    logic [FU_W-1:0]      disp_fu;
    logic [ROB_W-1:0]     disp_rob;

    logic                 iss_valid;
    logic                 iss_ready;
    logic [PAYLOAD_W-1:0] iss_payload;
    logic [PREG_W-1:0]    iss_rs1;
    logic [PREG_W-1:0]    iss_rs2;
    logic [PREG_W-1:0]    iss_rd;
    logic [FU_W-1:0]      iss_fu;
    logic [ROB_W-1:0]     iss_rob;

    modport master (
        output disp_valid, disp_payload, disp_rs1, disp_rs2, disp_rd,
        output disp_rs1_rdy, disp_rs2_rdy, disp_fu, disp_rob,
        input  disp_ready,
        input  iss_valid, iss_payload, iss_rs1, iss_rs2, iss_rd,
        input  iss_fu, iss_rob,
        output iss_ready
    );

    modport slave (
        input  disp_valid, disp_payload, disp_rs1, disp_rs2, disp_rd,
        input  disp_rs1_rdy, disp_rs2_rdy, disp_fu, disp_rob,
        output disp_ready,
        output iss_valid, iss_payload, iss_rs1, iss_rs2, iss_rd,
        output iss_fu, iss_rob,
        input  iss_ready
    );

endinterface

// File: rtl/age_issue_queue_age_matrix_select.sv
// Age matrix with oldest-ready one-hot grant.
// Ports: clk, rst, i_alloc/i_free (one-hot slots), i_ready, o_grant.
module age_matrix_select #(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DEPTH-1:0] i_alloc,
    input  logic [DEPTH-1:0] i_free,
    input  logic [DEPTH-1:0] i_ready,
    output logic [DEPTH-1:0] o_grant
);

    // r_age[i][j] = 1 : slot i is older than slot j
    logic [DEPTH-1:0] r_age [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [DEPTH-1:0] w_keep;
    logic [DEPTH-1:0] w_blk;

    assign w_keep = r_vld & ~i_free;

    always_comb begin
        w_blk   = '0;
        o_grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (i_ready[j] && r_age[j][i]) w_blk[i] = 1'b1;
            end
            o_grant[i] = i_ready[i] && !w_blk[i];
        end
    end

    // New slot becomes youngest: every surviving entry is older than it.
    // Freed or reallocated slots have their row and column cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
        end else begin
            r_vld <= w_keep | i_alloc;
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (i_alloc[j])
                        r_age[i][j] <= w_keep[i];
                    else if (i_alloc[i] || i_free[i] || i_free[j])
                        r_age[i][j] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/age_issue_queue.sv
// Out-of-order issue queue, oldest-ready-first selection.
// Ports: clk, rst, bus (dispatch/issue), wakeup, fu_ready, stall, flush, occupancy.
module age_issue_queue
    import issue_pkg::*;
#(
    parameter int DEPTH     = IQ_DEPTH,
    parameter int ROB_W     = IQ_ROB_W,
    parameter int PREG_W    = IQ_PREG_W,
    parameter int FU_W      = IQ_FU_W,
    parameter int NUM_WK    = IQ_NUM_WK,
    parameter int PAYLOAD_W = IQ_PAYLOAD_W
) (
    input  logic                       clk,
    input  logic                       rst,
    age_issue_queue_if.slave           bus,
    input  logic [NUM_WK-1:0]          wk_valid,
    input  logic [NUM_WK*PREG_W-1:0]   wk_tag,
    input  logic [(2**FU_W)-1:0]       fu_ready,
    input  logic                       stall,
    input  logic                       flush_valid,
    input  logic [(2**ROB_W)-1:0]      flush_mask,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]     r_vld;
    logic [DEPTH-1:0]     r_rdy1;
    logic [DEPTH-1:0]     r_rdy2;
    logic [PAYLOAD_W-1:0] r_pay [DEPTH];
    logic [PREG_W-1:0]    r_rs1 [DEPTH];
    logic [PREG_W-1:0]    r_rs2 [DEPTH];
    logic [PREG_W-1:0]    r_rd  [DEPTH];
    logic [FU_W-1:0]      r_fu  [DEPTH];
    logic [ROB_W-1:0]     r_rob [DEPTH];

    logic                 r_ovld;
    logic [PAYLOAD_W-1:0] r_opay;
    logic [PREG_W-1:0]    r_ors1;
    logic [PREG_W-1:0]    r_ors2;
    logic [PREG_W-1:0]    r_ord;
    logic [FU_W-1:0]      r_ofu;
    logic [ROB_W-1:0]     r_orob;

    logic                 w_full;
    logic                 w_disp_fire;
    logic                 w_found;
    logic                 w_adv;
    logic [DEPTH-1:0]     w_alloc;
    logic [DEPTH-1:0]     w_wk1;
    logic [DEPTH-1:0]     w_wk2;
    logic [DEPTH-1:0]     w_rdy;
    logic [DEPTH-1:0]     w_req;
    logic [DEPTH-1:0]     w_grant;
    logic [DEPTH-1:0]     w_kill;
    logic [DEPTH-1:0]     w_free;
    logic                 w_d_wk1;
    logic                 w_d_wk2;
    logic                 w_gany;
    logic                 w_gflush;
    logic [PAYLOAD_W-1:0] w_g_pay;
    logic [PREG_W-1:0]    w_g_rs1;
    logic [PREG_W-1:0]    w_g_rs2;
    logic [PREG_W-1:0]    w_g_rd;
    logic [FU_W-1:0]      w_g_fu;
    logic [ROB_W-1:0]     w_g_rob;
    logic [OCC_W-1:0]     w_occ;

    // Tag 0 never matches a wakeup; it is treated as ready at capture.
    function automatic logic f_wake(
        input logic [PREG_W-1:0]        tag,
        input logic [NUM_WK-1:0]        v,
        input logic [NUM_WK*PREG_W-1:0] t
    );
        logic m;
        m = 1'b0;
        for (int k = 0; k < NUM_WK; k++) begin
            if (v[k] && t[k*PREG_W +: PREG_W] == tag) m = 1'b1;
        end
        return m && (tag != '0);
    endfunction

    assign w_full         = &r_vld;
    assign bus.disp_ready = !w_full && !flush_valid && !stall && !rst;
    assign w_disp_fire    = bus.disp_valid && bus.disp_ready;
    assign w_adv          = !r_ovld || bus.iss_ready;
    assign w_d_wk1        = f_wake(bus.disp_rs1, wk_valid, wk_tag);
    assign w_d_wk2        = f_wake(bus.disp_rs2, wk_valid, wk_tag);

    always_comb begin
        w_alloc = '0;
        w_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!r_vld[i] && !w_found) begin
                w_alloc[i] = w_disp_fire;
                w_found    = 1'b1;
            end
        end
    end

    always_comb begin
        w_wk1  = '0;
        w_wk2  = '0;
        w_rdy  = '0;
        w_kill = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_wk1[i]  = f_wake(r_rs1[i], wk_valid, wk_tag);
            w_wk2[i]  = f_wake(r_rs2[i], wk_valid, wk_tag);
            w_rdy[i]  = r_vld[i] && (r_rdy1[i] || w_wk1[i])
                     && (r_rdy2[i] || w_wk2[i]) && fu_ready[r_fu[i]];
            w_kill[i] = flush_valid && r_vld[i] && flush_mask[r_rob[i]];
        end
    end

    assign w_req  = w_rdy & {DEPTH{w_adv}};
    assign w_free = w_grant | w_kill;

    age_matrix_select #(.DEPTH(DEPTH)) u_age (
        .clk     (clk),
        .rst     (rst),
        .i_alloc (w_alloc),
        .i_free  (w_free),
        .i_ready (w_req),
        .o_grant (w_grant)
    );

    always_comb begin
        w_gany  = 1'b0;
        w_g_pay = '0;
        w_g_rs1 = '0;
        w_g_rs2 = '0;
        w_g_rd  = '0;
        w_g_fu  = '0;
        w_g_rob = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_grant[i]) begin
                w_gany  = 1'b1;
                w_g_pay = r_pay[i];
                w_g_rs1 = r_rs1[i];
                w_g_rs2 = r_rs2[i];
                w_g_rd  = r_rd[i];
                w_g_fu  = r_fu[i];
                w_g_rob = r_rob[i];
            end
        end
    end

    assign w_gflush = flush_valid && flush_mask[w_g_rob];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= '0;
            r_rdy1 <= '0;
            r_rdy2 <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alloc[i]) begin
                    r_vld[i]  <= 1'b1;
                    r_rdy1[i] <= bus.disp_rs1_rdy || w_d_wk1
                              || (bus.disp_rs1 == '0);
                    r_rdy2[i] <= bus.disp_rs2_rdy || w_d_wk2
                              || (bus.disp_rs2 == '0);
                    r_pay[i]  <= bus.disp_payload;
                    r_rs1[i]  <= bus.disp_rs1;
                    r_rs2[i]  <= bus.disp_rs2;
                    r_rd[i]   <= bus.disp_rd;
                    r_fu[i]   <= bus.disp_fu;
                    r_rob[i]  <= bus.disp_rob;
                end else if (w_free[i]) begin
                    r_vld[i] <= 1'b0;
                end else if (r_vld[i]) begin
                    r_rdy1[i] <= r_rdy1[i] || w_wk1[i];
                    r_rdy2[i] <= r_rdy2[i] || w_wk2[i];
                end
            end
        end
    end

    // A granted-but-flushed entry still leaves the queue; it just
    // never becomes visible on the issue port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovld <= 1'b0;
            r_opay <= '0;
            r_ors1 <= '0;
            r_ors2 <= '0;
            r_ord  <= '0;
            r_ofu  <= '0;
            r_orob <= '0;
        end else if (w_adv) begin
            r_ovld <= w_gany && !w_gflush;
            if (w_gany) begin
                r_opay <= w_g_pay;
                r_ors1 <= w_g_rs1;
                r_ors2 <= w_g_rs2;
                r_ord  <= w_g_rd;
                r_ofu  <= w_g_fu;
                r_orob <= w_g_rob;
            end
        end else if (flush_valid && flush_mask[r_orob]) begin
            r_ovld <= 1'b0;
        end
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) w_occ = w_occ + OCC_W'(r_vld[i]);
    end

    assign occupancy       = w_occ;
    assign bus.iss_valid   = r_ovld;
    assign bus.iss_payload = r_opay;
    assign bus.iss_rs1     = r_ors1;
    assign bus.iss_rs2     = r_ors2;
    assign bus.iss_rd      = r_ord;
    assign bus.iss_fu      = r_ofu;
    assign bus.iss_rob     = r_orob;

endmodule

// File: tb/tb_age_issue_queue.sv
// Directed self-checking bench for age_issue_queue.
// Vector table for single-entry readiness plus multi-cycle sequences.
module tb_age_issue_queue;
    import issue_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  wk_valid;
    logic [13:0] wk_tag;
    logic [7:0]  fu_ready;
    logic        stall;
    logic        flush_valid;
    logic [7:0]  flush_mask;
    logic [3:0]  occupancy;

    int total;
    int bad;

    age_issue_queue_if #(
        .PAYLOAD_W(112), .PREG_W(7), .FU_W(3), .ROB_W(3)
    ) bus ();

    age_issue_queue #(
        .DEPTH(8), .ROB_W(3), .PREG_W(7), .FU_W(3),
        .NUM_WK(2), .PAYLOAD_W(112)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .wk_valid    (wk_valid),
        .wk_tag      (wk_tag),
        .fu_ready    (fu_ready),
        .stall       (stall),
        .flush_valid (flush_valid),
        .flush_mask  (flush_mask),
        .occupancy   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int rs1;
        int rs2;
        int r1;
        int r2;
        int fu;
        int fur;
        int wk;
        int ev;
    } vec_t;

    vec_t vt [8];

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst                  = 1'b1;
        wk_valid             = '0;
        wk_tag               = '0;
        fu_ready             = 8'hFF;
        stall                = 1'b0;
        flush_valid          = 1'b0;
        flush_mask           = '0;
        bus.disp_valid       = 1'b0;
        bus.disp_payload     = '0;
        bus.disp_rs1         = '0;
        bus.disp_rs2         = '0;
        bus.disp_rd          = '0;
        bus.disp_rs1_rdy     = 1'b0;
        bus.disp_rs2_rdy     = 1'b0;
        bus.disp_fu          = '0;
        bus.disp_rob         = '0;
        bus.iss_ready        = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic disp(input int rob, input int a, input int b,
                        input int ra, input int rb, input int fu,
                        input int pay);
        bus.disp_rob     = 3'(rob);
        bus.disp_rs1     = 7'(a);
        bus.disp_rs2     = 7'(b);
        bus.disp_rd      = 7'(rob + 8);
        bus.disp_rs1_rdy = 1'(ra);
        bus.disp_rs2_rdy = 1'(rb);
        bus.disp_fu      = 3'(fu);
        bus.disp_payload = 112'(pay);
        bus.disp_valid   = 1'b1;
        #1;
        check("disp_ready", 128'(bus.disp_ready), 128'(1));
        tick();
        bus.disp_valid = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        vt[0] = '{5,  6,   1, 1, 0, 'h01, 0,    1};
        vt[1] = '{5,  6,   1, 1, 0, 'hFE, 0,    0};
        vt[2] = '{5,  6,   0, 1, 0, 'hFF, 5,    1};
        vt[3] = '{5,  6,   0, 1, 0, 'hFF, 6,    0};
        vt[4] = '{0,  0,   0, 0, 3, 'h08, 0,    1};
        vt[5] = '{1,  0,   0, 0, 1, 'hFF, 0,    0};
        vt[6] = '{9,  'h22, 1, 0, 2, 'hFF, 'h22, 1};
        vt[7] = '{3,  4,   1, 1, 7, 'h80, 0,    1};

        // reset state
        do_reset();
        rst = 1'b1;
        bus.disp_valid = 1'b1;
        tick();
        check("rst_iss_valid", 128'(bus.iss_valid), 128'(0));
        check("rst_disp_ready", 128'(bus.disp_ready), 128'(0));
        check("rst_occ", 128'(occupancy), 128'(0));
        check("rst_payload", 128'(bus.iss_payload), 128'(0));
        check("rst_rob", 128'(bus.iss_rob), 128'(0));
        bus.disp_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("post_rst_ready", 128'(bus.disp_ready), 128'(1));

        // single-entry readiness table
        for (int v = 0; v < 8; v++) begin
            do_reset();
            fu_ready = 8'(vt[v].fur);
            disp(1, vt[v].rs1, vt[v].rs2, vt[v].r1, vt[v].r2,
                 vt[v].fu, 'h100 + v);
            wk_valid = 2'b01;
            wk_tag   = {7'd0, 7'(vt[v].wk)};
            tick();
            wk_valid = '0;
            check($sformatf("vec%0d_valid", v),
                  128'(bus.iss_valid), 128'(vt[v].ev));
            check($sformatf("vec%0d_fu", v), 128'(bus.iss_fu),
                  128'(vt[v].ev != 0 ? vt[v].fu : 0));
            check($sformatf("vec%0d_occ", v), 128'(occupancy),
                  128'(vt[v].ev != 0 ? 0 : 1));
        end

        // oldest-first across a reused slot
        do_reset();
        disp(1, 'h10, 'h11, 0, 0, int'(FU_ALU), 'hA);
        disp(2, 'h10, 'h11, 0, 0, int'(FU_ALU), 'hB);
        disp(3, 'h10, 'h11, 0, 0, int'(FU_ALU), 'hC);
        check("age_occ3", 128'(occupancy), 128'(3));
        flush_valid = 1'b1;
        flush_mask  = 8'h02;
        tick();
        flush_valid = 1'b0;
        check("age_occ2", 128'(occupancy), 128'(2));
        disp(4, 'h10, 'h11, 0, 0, int'(FU_ALU), 'hD);
        check("age_occ3b", 128'(occupancy), 128'(3));
        check("age_idle", 128'(bus.iss_valid), 128'(0));
        wk_valid = 2'b11;
        wk_tag   = {7'h11, 7'h10};
        tick();
        wk_valid = '0;
        check("age_1st_v", 128'(bus.iss_valid), 128'(1));
        check("age_1st", 128'(bus.iss_rob), 128'(2));
        tick();
        check("age_2nd", 128'(bus.iss_rob), 128'(3));
        tick();
        check("age_3rd", 128'(bus.iss_rob), 128'(4));
        check("age_3rd_pay", 128'(bus.iss_payload), 128'('hD));
        tick();
        check("age_drained", 128'(bus.iss_valid), 128'(0));

        // zero-cycle wakeup on port 1
        do_reset();
        disp(0, 'h15, 'h03, 0, 1, int'(FU_ALU), 'h77);
        tick();
        check("byp_wait", 128'(bus.iss_valid), 128'(0));
        wk_valid = 2'b10;
        wk_tag   = {7'h15, 7'h00};
        tick();
        wk_valid = '0;
        check("byp_valid", 128'(bus.iss_valid), 128'(1));
        check("byp_rs1", 128'(bus.iss_rs1), 128'('h15));

        // wakeup captured during dispatch
        do_reset();
        wk_valid = 2'b01;
        wk_tag   = {7'h00, 7'h22};
        disp(0, 0, 'h22, 0, 0, int'(FU_LOAD), 'h88);
        wk_valid = '0;
        check("cap_n", 128'(bus.iss_valid), 128'(0));
        tick();
        check("cap_n2", 128'(bus.iss_valid), 128'(1));
        check("cap_rs2", 128'(bus.iss_rs2), 128'('h22));

        // backpressure then drain
        do_reset();
        bus.iss_ready = 1'b0;
        disp(0, 1, 2, 1, 1, int'(FU_ALU), 100);
        disp(1, 1, 2, 1, 1, int'(FU_ALU), 101);
        disp(2, 1, 2, 1, 1, int'(FU_ALU), 102);
        tick();
        check("bp_valid", 128'(bus.iss_valid), 128'(1));
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_pay", 128'(bus.iss_payload), 128'(100));
            check("bp_occ", 128'(occupancy), 128'(2));
        end
        bus.iss_ready = 1'b1;
        tick();
        check("bp_d1", 128'(bus.iss_payload), 128'(101));
        check("bp_d1_occ", 128'(occupancy), 128'(1));
        tick();
        check("bp_d2", 128'(bus.iss_payload), 128'(102));
        check("bp_d2_v", 128'(bus.iss_valid), 128'(1));
        tick();
        check("bp_d3", 128'(bus.iss_valid), 128'(0));

        // full queue and ROB flush
        do_reset();
        bus.iss_ready = 1'b0;
        disp(3, 1, 2, 1, 1, int'(FU_ALU), 'hAA);
        for (int r = 0; r < 8; r++)
            disp(r, 'h30, 'h31, 0, 0, int'(FU_MUL), 'h200 + r);
        check("fl_occ8", 128'(occupancy), 128'(8));
        bus.disp_valid = 1'b1;
        #1;
        check("fl_full", 128'(bus.disp_ready), 128'(0));
        bus.disp_valid = 1'b0;
        check("fl_out_rob", 128'(bus.iss_rob), 128'(3));
        flush_valid = 1'b1;
        flush_mask  = 8'hF0;
        #1;
        check("fl_blk", 128'(bus.disp_ready), 128'(0));
        tick();
        check("fl_occ4", 128'(occupancy), 128'(4));
        check("fl_keep", 128'(bus.iss_valid), 128'(1));
        flush_mask = 8'h08;
        tick();
        flush_valid = 1'b0;
        check("fl_kill", 128'(bus.iss_valid), 128'(0));
        check("fl_occ3", 128'(occupancy), 128'(3));

        // same-cycle dispatch and issue
        do_reset();
        disp(0, 1, 2, 1, 1, int'(FU_ALU), 'h55);
        check("sc_occ1", 128'(occupancy), 128'(1));
        disp(1, 1, 2, 1, 1, int'(FU_ALU), 'h66);
        check("sc_occ_same", 128'(occupancy), 128'(1));
        check("sc_pay1", 128'(bus.iss_payload), 128'('h55));
        tick();
        check("sc_pay2", 128'(bus.iss_payload), 128'('h66));
        check("sc_occ0", 128'(occupancy), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
